store_drain_unit: RTL and testbench

- Sits directly downstream of the LSU store queue.
- Takes committed stores one at a time from the queue head and drives them into the DCache store port.
- Holds one in-flight store. Coalesces later cached stores to the same word while that store has not yet been accepted by the DCache. Handles DCache retry with a fixed backoff.
- Provides a drained indication for fence/ibar/uncached-ordering logic.

---
 rtl/core_config_pkg.sv | 4 +
 rtl/core_types_pkg.sv | 28 ++
 rtl/store_byte_merge.sv | 27 ++
 rtl/store_drain_unit.sv | 129 ++++++++++++
 tb/tb_store_drain_unit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/core_config_pkg.sv
// Core-wide tuning constants shared by the memory pipeline blocks.
package core_config;
  localparam int STORE_DRAIN_BACKOFF_CYCLES = 4;
endpackage

// File: rtl/core_types_pkg.sv
// Shared datapath types for the LSU / DCache store path.
package core_types;
  localparam int CORE_ADDR_W = 32;
  localparam int CORE_DATA_W = 32;
  localparam int CORE_STRB_W = CORE_DATA_W / 8;

  typedef struct packed {
    logic                   valid;
    logic [CORE_ADDR_W-1:0] addr;
    logic [CORE_DATA_W-1:0] data;
    logic [CORE_STRB_W-1:0] wstrb;
    logic                   uncached;
  } store_req_t;

  typedef struct packed {
    logic [CORE_ADDR_W-1:0] addr;
    logic [CORE_DATA_W-1:0] data;
    logic [CORE_STRB_W-1:0] wstrb;
    logic                   uncached;
  } dcache_store_req_t;

  typedef enum logic [1:0] {
    DRAIN_IDLE    = 2'd0,
    DRAIN_REQ     = 2'd1,
    DRAIN_WAIT    = 2'd2,
    DRAIN_BACKOFF = 2'd3
  } drain_state_e;
endpackage

// File: rtl/store_byte_merge.sv
// Combinational byte-lane merge of a newer store over an older one to the same word.
module store_byte_merge
  import core_types::*;
#(
  parameter int ADDR_WIDTH = CORE_ADDR_W,
  parameter int DATA_WIDTH = CORE_DATA_W
) (
  input  logic [ADDR_WIDTH-1:0]   i_old_addr,
  input  logic [DATA_WIDTH-1:0]   i_old_data,
  input  logic [DATA_WIDTH/8-1:0] i_old_wstrb,
  input  logic [ADDR_WIDTH-1:0]   i_new_addr,
  input  logic [DATA_WIDTH-1:0]   i_new_data,
  input  logic [DATA_WIDTH/8-1:0] i_new_wstrb,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [DATA_WIDTH/8-1:0] o_wstrb,
  output logic                    o_addr_match
);
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_lane
      assign o_data[8*gi +: 8] = i_new_wstrb[gi] ? i_new_data[8*gi +: 8] : i_old_data[8*gi +: 8];
    end
  endgenerate

  assign o_wstrb      = i_old_wstrb | i_new_wstrb;
  assign o_addr_match = (i_old_addr[ADDR_WIDTH-1:2] == i_new_addr[ADDR_WIDTH-1:2]);
endmodule

// File: rtl/store_drain_unit.sv
// Drains committed stores one at a time into the DCache store port, coalescing
// same-word cached stores while the held request is unaccepted, with retry backoff.
module store_drain_unit
  import core_types::*;
  import core_config::*;
#(
  parameter int ADDR_WIDTH     = CORE_ADDR_W,
  parameter int DATA_WIDTH     = CORE_DATA_W,
  parameter int BACKOFF_CYCLES = STORE_DRAIN_BACKOFF_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  store_req_t              store_req_i,
  output logic                    store_ready_o,
  output logic                    dcache_req_valid_o,
  input  logic                    dcache_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   dcache_req_addr_o,
  output logic [DATA_WIDTH-1:0]   dcache_req_data_o,
  output logic [DATA_WIDTH/8-1:0] dcache_req_wstrb_o,
  output logic                    dcache_req_uncached_o,
  input  logic                    dcache_resp_valid_i,
  input  logic                    dcache_resp_retry_i,
  output logic                    store_done_o,
  output logic                    drained_o
);
  localparam int CNT_WIDTH = $clog2(BACKOFF_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] BACKOFF_LOAD = CNT_WIDTH'(BACKOFF_CYCLES - 1);

  drain_state_e          r_state;
  dcache_store_req_t     r_hold;
  logic [CNT_WIDTH-1:0]  r_cnt;

  dcache_store_req_t     w_new;
  logic [DATA_WIDTH-1:0] w_merge_data;
  logic [DATA_WIDTH/8-1:0] w_merge_wstrb;
  logic                  w_addr_match;
  logic                  w_merge_window;
  logic                  w_merge_ok;
  logic                  w_done;
  logic                  w_take;
  logic                  w_accept;

  store_byte_merge #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .i_old_addr   (r_hold.addr),
    .i_old_data   (r_hold.data),
    .i_old_wstrb  (r_hold.wstrb),
    .i_new_addr   (store_req_i.addr),
    .i_new_data   (store_req_i.data),
    .i_new_wstrb  (store_req_i.wstrb),
    .o_data       (w_merge_data),
    .o_wstrb      (w_merge_wstrb),
    .o_addr_match (w_addr_match)
  );

  assign w_new = '{addr:     {store_req_i.addr[ADDR_WIDTH-1:2], 2'b00},
                   data:     store_req_i.data,
                   wstrb:    store_req_i.wstrb,
                   uncached: store_req_i.uncached};

  // Merging is only safe while the DCache cannot be sampling the payload this edge.
  assign w_merge_window = ((r_state == DRAIN_REQ) && !dcache_req_ready_i) || (r_state == DRAIN_BACKOFF);
  assign w_merge_ok     = w_merge_window && !r_hold.uncached && store_req_i.valid &&
                          !store_req_i.uncached && w_addr_match;
  assign w_done         = (r_state == DRAIN_WAIT) && dcache_resp_valid_i && !dcache_resp_retry_i;
  assign w_take         = (r_state == DRAIN_IDLE) || w_done;
  assign store_ready_o  = rst && (w_take || w_merge_ok);
  assign w_accept       = store_req_i.valid && store_ready_o;

  assign dcache_req_valid_o    = (r_state == DRAIN_REQ);
  assign dcache_req_addr_o     = r_hold.addr;
  assign dcache_req_data_o     = r_hold.data;
  assign dcache_req_wstrb_o    = r_hold.wstrb;
  assign dcache_req_uncached_o = r_hold.uncached;
  assign store_done_o          = w_done;
  assign drained_o             = (r_state == DRAIN_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DRAIN_IDLE;
      r_hold  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        DRAIN_IDLE: begin
          if (w_accept) begin
            r_hold  <= w_new;
            r_state <= DRAIN_REQ;
          end
        end
        DRAIN_REQ: begin
          if (dcache_req_ready_i) begin
            r_state <= DRAIN_WAIT;
          end else if (w_accept) begin
            r_hold.data  <= w_merge_data;
            r_hold.wstrb <= w_merge_wstrb;
          end
        end
        DRAIN_WAIT: begin
          if (dcache_resp_valid_i) begin
            if (dcache_resp_retry_i) begin
              r_cnt   <= BACKOFF_LOAD;
              r_state <= DRAIN_BACKOFF;
            end else if (w_accept) begin
              r_hold  <= w_new;
              r_state <= DRAIN_REQ;
            end else begin
              r_state <= DRAIN_IDLE;
            end
          end
        end
        DRAIN_BACKOFF: begin
          if (w_accept) begin
            r_hold.data  <= w_merge_data;
            r_hold.wstrb <= w_merge_wstrb;
          end
          if (r_cnt == '0) begin
            r_state <= DRAIN_REQ;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= DRAIN_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_drain_unit.sv
// Randomized scoreboard bench for store_drain_unit against a queue-based reference model.
`timescale 1ns/1ps
module tb_store_drain_unit;
  import core_types::*;
  import core_config::*;

  localparam int B = STORE_DRAIN_BACKOFF_CYCLES;

  logic        clk = 1'b0;
  logic        rst;
  store_req_t  store_req;
  logic        store_ready, dvalid, dready, dunc, rvalid, rretry, done, drained;
  logic [31:0] daddr, ddata;
  logic [3:0]  dwstrb;

  always #5 clk = ~clk;

  store_drain_unit dut (
    .clk                   (clk),
    .rst                   (rst),
    .store_req_i           (store_req),
    .store_ready_o         (store_ready),
    .dcache_req_valid_o    (dvalid),
    .dcache_req_ready_i    (dready),
    .dcache_req_addr_o     (daddr),
    .dcache_req_data_o     (ddata),
    .dcache_req_wstrb_o    (dwstrb),
    .dcache_req_uncached_o (dunc),
    .dcache_resp_valid_i   (rvalid),
    .dcache_resp_retry_i   (rretry),
    .store_done_o          (done),
    .drained_o             (drained)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the store the unit owes the DCache, whether it is
  // currently with the DCache, and how many silent backoff cycles remain.
  dcache_store_req_t q[$];
  bit                issued = 0;
  int                bo = 0;

  function automatic dcache_store_req_t merge_model(dcache_store_req_t old, store_req_t nw);
    dcache_store_req_t m;
    m = old;
    for (int i = 0; i < 4; i++)
      if (nw.wstrb[i]) m.data[8*i +: 8] = nw.data[8*i +: 8];
    m.wstrb = old.wstrb | nw.wstrb;
    return m;
  endfunction

  function automatic store_req_t gen_store();
    store_req_t s;
    int r;
    r          = $urandom_range(0, 7);
    s.valid    = 1'b1;
    s.data     = $urandom;
    s.wstrb    = 4'($urandom_range(1, 15));
    s.uncached = (r == 7);
    case (r)
      0, 1, 2, 3: s.addr = 32'h0000_0100 + 32'($urandom_range(0, 3));
      4, 5:       s.addr = 32'h0000_0104 + 32'($urandom_range(0, 3));
      6:          s.addr = 32'h1000_0004 + 32'($urandom_range(0, 3));
      default:    s.addr = 32'h1FE0_0000 + 32'($urandom_range(0, 3));
    endcase
    return s;
  endfunction

  initial begin : monitor
    dcache_store_req_t obs, nreq;
    bit mergeable, completion, hs, acc;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        q.delete();
        issued = 0;
        bo     = 0;
        continue;
      end
      obs = '{addr: daddr, data: ddata, wstrb: dwstrb, uncached: dunc};
      chk("req_valid", dvalid, q.size() > 0 && !issued && bo == 0);
      if (dvalid && q.size() > 0) chk("req_payload", obs, q[0]);
      completion = rvalid && !rretry && issued;
      chk("store_done", done, completion);
      chk("drained", drained, q.size() == 0);
      mergeable = q.size() > 0 && !issued && (bo > 0 || !dready) && !q[0].uncached &&
                  store_req.valid && !store_req.uncached &&
                  store_req.addr[31:2] == q[0].addr[31:2];
      if (store_req.valid)
        chk("store_ready", store_ready, q.size() == 0 || completion || mergeable);

      hs  = dvalid && dready;
      acc = store_req.valid && store_ready;
      if (bo > 0) bo--;
      if (rvalid && issued) begin
        issued = 0;
        if (rretry) bo = B;
        else void'(q.pop_front());
      end
      if (hs) issued = 1;
      if (acc) begin
        if (mergeable) begin
          q[0] = merge_model(q[0], store_req);
        end else begin
          nreq = '{addr: {store_req.addr[31:2], 2'b00}, data: store_req.data,
                   wstrb: store_req.wstrb, uncached: store_req.uncached};
          q.push_back(nreq);
        end
      end
    end
  end

  initial begin : driver
    int resp_wait;
    bit popped, hs, did_reset;
    resp_wait = -1;
    did_reset = 0;
    rst       = 1'b0;
    store_req = '0;
    dready    = 1'b0;
    rvalid    = 1'b0;
    rretry    = 1'b0;
    store_req = gen_store();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", store_ready, 1'b0);
    chk("rst_valid", dvalid, 1'b0);
    chk("rst_drained", drained, 1'b1);
    chk("rst_done", done, 1'b0);
    rst = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      popped = store_req.valid && store_ready;
      hs     = dvalid && dready;
      if (hs) resp_wait = $urandom_range(0, 2);
      @(posedge clk);
      #1;
      if (popped) store_req.valid = 1'b0;
      if (!store_req.valid && $urandom_range(0, 9) < 7) store_req = gen_store();
      dready = ($urandom_range(0, 2) != 0);
      rvalid = 1'b0;
      rretry = 1'b0;
      if (c > 2000 && !did_reset && hs) begin
        // The unit is now in WAIT with a store held; pull reset with no clock edge.
        store_req.valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", dvalid, 1'b0);
        chk("arst_drained", drained, 1'b1);
        chk("arst_ready", store_ready, 1'b0);
        chk("arst_done", done, 1'b0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        resp_wait = -1;
        did_reset = 1;
        store_req = gen_store();
      end else if (resp_wait == 0) begin
        rvalid    = 1'b1;
        rretry    = ($urandom_range(0, 3) == 0);
        resp_wait = -1;
      end else if (resp_wait > 0) begin
        resp_wait--;
      end
    end

    chk("reset_exercised", did_reset, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
